// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO register file: stall-bus encoding, forwarding indices, scoreboard states.
package hilo_pkg;

    localparam int STALL_W_DEF = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam int FWD_EX  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_PEND = 1'b1
    } sb_state_e;

endpackage

// File: rtl/hilo_fwd_mux.sv
// Per-half forwarding priority mux; combinational, no backpressure.
// Youngest stage wins, then older stages, then the mul/div result, then the architectural value.
module hilo_fwd_mux #(
    parameter int DATA_W     = 32,
    parameter int FWD_STAGES = 3
) (
    input  logic [FWD_STAGES-1:0]        fwd_we_i,
    input  logic [FWD_STAGES*DATA_W-1:0] fwd_dat_i,
    input  logic                         md_vld_i,
    input  logic [DATA_W-1:0]            md_dat_i,
    input  logic [DATA_W-1:0]            arch_i,
    output logic [DATA_W-1:0]            res_o
);

    always_comb begin
        res_o = arch_i;
        if (md_vld_i) res_o = md_dat_i;
        // Walk oldest to youngest so the youngest enabled stage is applied last.
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (fwd_we_i[i]) res_o = fwd_dat_i[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/hilo_file.sv
// HI/LO register file with forwarding, mul/div scoreboard and a 1-cycle registered read port into EX.
// Output register bubbles or holds per the stall bus; stall_req is combinational and independent of stall.
module hilo_file
    import hilo_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FWD_STAGES = 3,
    parameter int STALL_W    = STALL_W_DEF,
    parameter int RD_STAGE   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [STALL_W-1:0]           stall,
    input  logic [FWD_STAGES-1:0]        fwd_hi_we,
    input  logic [FWD_STAGES-1:0]        fwd_lo_we,
    input  logic [FWD_STAGES*DATA_W-1:0] fwd_hi,
    input  logic [FWD_STAGES*DATA_W-1:0] fwd_lo,
    input  logic                         rd_hi,
    input  logic                         rd_lo,
    input  logic                         md_start,
    input  logic                         md_done,
    input  logic [DATA_W-1:0]            md_hi,
    input  logic [DATA_W-1:0]            md_lo,
    input  logic                         md_flush,
    output logic [DATA_W-1:0]            hi_data,
    output logic [DATA_W-1:0]            lo_data,
    output logic                         md_busy,
    output logic                         stall_req
);

    localparam int CMT = FWD_STAGES - 1;

    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0] out_hi_q, out_hi_d, out_lo_q, out_lo_d;
    logic [DATA_W-1:0] res_hi, res_lo;
    sb_state_e         sb_q, sb_d;
    logic              md_wr;
    logic              stall_unused;

    assign md_wr        = md_done & ~md_flush;
    assign stall_unused = ^stall;

    hilo_fwd_mux #(.DATA_W(DATA_W), .FWD_STAGES(FWD_STAGES)) u_mux_hi (
        .fwd_we_i (fwd_hi_we),
        .fwd_dat_i(fwd_hi),
        .md_vld_i (md_wr),
        .md_dat_i (md_hi),
        .arch_i   (hi_q),
        .res_o    (res_hi)
    );

    hilo_fwd_mux #(.DATA_W(DATA_W), .FWD_STAGES(FWD_STAGES)) u_mux_lo (
        .fwd_we_i (fwd_lo_we),
        .fwd_dat_i(fwd_lo),
        .md_vld_i (md_wr),
        .md_dat_i (md_lo),
        .arch_i   (lo_q),
        .res_o    (res_lo)
    );

    // Commit beats a simultaneous mul/div completion.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (md_wr) begin
            hi_d = md_hi;
            lo_d = md_lo;
        end
        if (fwd_hi_we[CMT]) hi_d = fwd_hi[CMT*DATA_W +: DATA_W];
        if (fwd_lo_we[CMT]) lo_d = fwd_lo[CMT*DATA_W +: DATA_W];
    end

    always_comb begin
        sb_d = sb_q;
        if (md_start)                sb_d = SB_PEND;
        else if (md_done | md_flush) sb_d = SB_IDLE;
        md_busy   = (sb_q == SB_PEND);
        stall_req = (sb_q == SB_PEND) & ~md_done & (rd_hi | rd_lo | md_start);
    end

    always_comb begin
        out_hi_d = res_hi;
        out_lo_d = res_lo;
        if (stall[RD_STAGE] == Stop) begin
            if (stall[RD_STAGE+1] == NoStop) begin
                out_hi_d = '0;
                out_lo_d = '0;
            end else begin
                out_hi_d = out_hi_q;
                out_lo_d = out_lo_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            out_hi_q <= '0;
            out_lo_q <= '0;
            sb_q     <= SB_IDLE;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            out_hi_q <= out_hi_d;
            out_lo_q <= out_lo_d;
            sb_q     <= sb_d;
        end
    end

    assign hi_data = out_hi_q;
    assign lo_data = out_lo_q;

endmodule

// File: tb/tb_hilo_file.sv
// Directed self-checking bench for hilo_file.
module tb_hilo_file;

    localparam int W = 32;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [5:0]     stall;
    logic [N-1:0]   fwd_hi_we, fwd_lo_we;
    logic [N*W-1:0] fwd_hi, fwd_lo;
    logic           rd_hi, rd_lo, md_start, md_done, md_flush;
    logic [W-1:0]   md_hi, md_lo;
    logic [W-1:0]   hi_data, lo_data;
    logic           md_busy, stall_req;

    int errors = 0;
    int checks = 0;

    hilo_file dut (
        .clk(clk), .rst(rst), .stall(stall),
        .fwd_hi_we(fwd_hi_we), .fwd_lo_we(fwd_lo_we),
        .fwd_hi(fwd_hi), .fwd_lo(fwd_lo),
        .rd_hi(rd_hi), .rd_lo(rd_lo),
        .md_start(md_start), .md_done(md_done),
        .md_hi(md_hi), .md_lo(md_lo), .md_flush(md_flush),
        .hi_data(hi_data), .lo_data(lo_data),
        .md_busy(md_busy), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = '0; fwd_hi_we = '0; fwd_lo_we = '0; fwd_hi = '0; fwd_lo = '0;
        rd_hi = 0; rd_lo = 0; md_start = 0; md_done = 0; md_flush = 0;
        md_hi = '0; md_lo = '0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #1 rst = 1'b1;
        #1;
        chk("reset_hi", hi_data, 32'h0);
        chk("reset_lo", lo_data, 32'h0);
        chk("reset_busy", {31'b0, md_busy}, 32'h0);
        tick(); tick();
        rst = 1'b0;

        // Plain read after reset
        rd_hi = 1;
        tick();
        chk("rd0_hi", hi_data, 32'h0);
        chk("rd0_lo", lo_data, 32'h0);
        chk("rd0_busy", {31'b0, md_busy}, 32'h0);
        rd_hi = 0;

        // Stage 0 beats commit; commit lands in architectural HI
        fwd_hi_we = 3'b101;
        fwd_hi = {32'h2222_2222, 32'h0, 32'h1111_1111};
        tick();
        chk("fwd_prio_hi", hi_data, 32'h1111_1111);
        idle();
        tick();
        chk("arch_hi_commit", hi_data, 32'h2222_2222);
        chk("arch_lo_untouched", lo_data, 32'h0);

        // Mul/div pending: reads stall until done
        md_start = 1;
        #1 chk("start_idle_noreq", {31'b0, stall_req}, 32'h0);
        tick();
        md_start = 0; rd_lo = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("pend_stall_req", {31'b0, stall_req}, 32'h1);
            chk("pend_busy", {31'b0, md_busy}, 32'h1);
            tick();
        end
        md_done = 1; md_lo = 32'hDEAD_BEEF; md_hi = 32'h1234_5678;
        #1 chk("done_noreq", {31'b0, stall_req}, 32'h0);
        tick();
        chk("md_fwd_lo", lo_data, 32'hDEAD_BEEF);
        chk("md_fwd_hi", hi_data, 32'h1234_5678);
        chk("done_busy", {31'b0, md_busy}, 32'h0);
        idle();

        // Flush with done discards the result
        md_start = 1;
        tick();
        md_start = 0; md_done = 1; md_flush = 1; md_hi = 32'h5; md_lo = 32'h6;
        tick();
        chk("flush_busy", {31'b0, md_busy}, 32'h0);
        chk("flush_nofwd_hi", hi_data, 32'h1234_5678);
        idle();
        tick();
        chk("flush_arch_hi", hi_data, 32'h1234_5678);
        chk("flush_arch_lo", lo_data, 32'hDEAD_BEEF);

        // Stall bus: hold then bubble
        fwd_hi_we = 3'b010; fwd_lo_we = 3'b010;
        fwd_hi = {32'h0, 32'hA5A5_A5A5, 32'h0};
        fwd_lo = {32'h0, 32'h5A5A_5A5A, 32'h0};
        tick();
        chk("mid_fwd_hi", hi_data, 32'hA5A5_A5A5);
        fwd_hi_we = 3'b001; fwd_hi = {32'h0, 32'h0, 32'h0BAD_0BAD};
        fwd_lo_we = 3'b000;
        stall = 6'b001100;
        tick();
        chk("hold_hi", hi_data, 32'hA5A5_A5A5);
        chk("hold_lo", lo_data, 32'h5A5A_5A5A);
        stall = 6'b000100;
        tick();
        chk("bubble_hi", hi_data, 32'h0);
        chk("bubble_lo", lo_data, 32'h0);
        idle();

        // Commit beats mul/div completion in the same cycle
        fwd_hi_we = 3'b100; fwd_hi = {32'h0000_0077, 64'h0};
        md_done = 1; md_hi = 32'h0000_0088; md_lo = 32'h0000_0099;
        tick();
        chk("cmt_vs_md_fwd_hi", hi_data, 32'h0000_0077);
        chk("cmt_vs_md_fwd_lo", lo_data, 32'h0000_0099);
        idle();
        tick();
        chk("cmt_vs_md_arch_hi", hi_data, 32'h0000_0077);
        chk("cmt_vs_md_arch_lo", lo_data, 32'h0000_0099);

        // Back-to-back: start with done keeps pending and writes result
        md_start = 1; md_done = 1; md_hi = 32'hCAFE_0001; md_lo = 32'hCAFE_0002;
        #1 chk("b2b_noreq", {31'b0, stall_req}, 32'h0);
        tick();
        chk("b2b_busy", {31'b0, md_busy}, 32'h1);
        chk("b2b_fwd_hi", hi_data, 32'hCAFE_0001);
        idle();
        md_start = 1;
        #1 chk("second_issue_req", {31'b0, stall_req}, 32'h1);
        md_start = 0; md_flush = 1;
        tick();
        chk("b2b_flushed_busy", {31'b0, md_busy}, 32'h0);
        chk("b2b_arch_hi", hi_data, 32'hCAFE_0001);
        chk("b2b_arch_lo", lo_data, 32'hCAFE_0002);
        idle();

        // Async reset mid-cycle with an op pending
        md_start = 1;
        tick();
        md_start = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_hi", hi_data, 32'h0);
        chk("arst_lo", lo_data, 32'h0);
        chk("arst_busy", {31'b0, md_busy}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_arch_hi", hi_data, 32'h0);
        chk("arst_arch_lo", lo_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
